// File: rtl/csa_pkg.sv
// Shared helpers for the pipelined carry-select adder: stage count, configuration check and
// the width-independent part of each stage's payload.
package csa_pkg;

   function automatic int unsigned nblk_of(input int unsigned width, input int unsigned block);
      return (block == 0) ? 1 : width / block;
   endfunction

   function automatic bit cfg_ok(input int unsigned width, input int unsigned block);
      return (block >= 1) && (width >= block) && ((width % block) == 0);
   endfunction

   // Partial sum and remaining operand slices depend on WIDTH/BLOCK and live beside this.
   typedef struct packed {
      logic valid;
      logic carry;
   } stage_ctl_t;

endpackage

// File: rtl/carry_select_block.sv
// Carry-select block: ripples both carry-in cases in parallel and picks one with the real carry.
module carry_select_block #(
   parameter int unsigned BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] bx,
   input  logic             ci,
   output logic [BLOCK-1:0] s,
   output logic             co,
   output logic             cmsb
);
   logic [BLOCK-1:0] p, g, s0, s1;
   logic [BLOCK:0]   c0, c1;

   assign p = a ^ bx;
   assign g = a & bx;

   always_comb begin
      c0    = '0;
      c1    = '0;
      c1[0] = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
         c0[i+1] = g[i] | (p[i] & c0[i]);
         c1[i+1] = g[i] | (p[i] & c1[i]);
      end
   end

   assign s0   = p ^ c0[BLOCK-1:0];
   assign s1   = p ^ c1[BLOCK-1:0];
   assign s    = ci ? s1 : s0;
   assign co   = ci ? c1[BLOCK] : c0[BLOCK];
   assign cmsb = ci ? c1[BLOCK-1] : c0[BLOCK-1];

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor: stage k resolves block k; upper operand slices are
// skewed forward and resolved low sums ride along so a whole result exits at once.
module pipelined_carry_select_adder
   import csa_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int unsigned NBLK = nblk_of(WIDTH, BLOCK);

   if (!cfg_ok(WIDTH, BLOCK)) begin : g_cfg_check
      $error("WIDTH must be a non-zero multiple of BLOCK");
   end

   logic             en;
   logic [WIDTH-1:0] bx_in;
   logic             c0_in;

   assign bx_in = b ^ {WIDTH{sub}};
   assign c0_in = sub | cin;

   for (genvar k = 0; k < NBLK; k++) begin : g_stg
      localparam int unsigned LoW = (k + 1) * BLOCK;

      stage_ctl_t       ctl_q;
      logic [LoW-1:0]   s_q;
      logic [LoW-1:0]   s_in;
      logic             v_in;
      logic [BLOCK-1:0] sa, sbx, ss;
      logic             sci, sco;

      if (k == 0) begin : g_src
         assign sa   = a[BLOCK-1:0];
         assign sbx  = bx_in[BLOCK-1:0];
         assign sci  = c0_in;
         assign v_in = in_valid && en;
         assign s_in = ss;
      end else begin : g_src
         assign sa   = g_stg[k-1].g_fwd.ra_q[BLOCK-1:0];
         assign sbx  = g_stg[k-1].g_fwd.rbx_q[BLOCK-1:0];
         assign sci  = g_stg[k-1].ctl_q.carry;
         assign v_in = g_stg[k-1].ctl_q.valid;
         assign s_in = {ss, g_stg[k-1].s_q};
      end

      if (k == NBLK - 1) begin : g_last
         logic scm, cm_q;

         carry_select_block #(.BLOCK(BLOCK)) u_csb (
            .a   (sa),
            .bx  (sbx),
            .ci  (sci),
            .s   (ss),
            .co  (sco),
            .cmsb(scm)
         );

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cm_q <= 1'b0;
            end else if (en) begin
               cm_q <= scm;
            end
         end
      end else begin : g_mid
         carry_select_block #(.BLOCK(BLOCK)) u_csb (
            .a   (sa),
            .bx  (sbx),
            .ci  (sci),
            .s   (ss),
            .co  (sco),
            .cmsb()
         );
      end

      // Operand bits above this block, still waiting for their stage.
      if (k < NBLK - 1) begin : g_fwd
         localparam int unsigned HiW = WIDTH - LoW;

         logic [HiW-1:0] ra_q, rbx_q, ra_in, rbx_in;

         if (k == 0) begin : g_op
            assign ra_in  = a[WIDTH-1:BLOCK];
            assign rbx_in = bx_in[WIDTH-1:BLOCK];
         end else begin : g_op
            assign ra_in  = g_stg[k-1].g_fwd.ra_q[HiW+BLOCK-1:BLOCK];
            assign rbx_in = g_stg[k-1].g_fwd.rbx_q[HiW+BLOCK-1:BLOCK];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ra_q  <= '0;
               rbx_q <= '0;
            end else if (en) begin
               ra_q  <= ra_in;
               rbx_q <= rbx_in;
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            ctl_q <= '0;
            s_q   <= '0;
         end else if (en) begin
            ctl_q.valid <= v_in;
            ctl_q.carry <= sco;
            s_q         <= s_in;
         end
      end
   end

   assign out_valid = g_stg[NBLK-1].ctl_q.valid;
   assign en        = !out_valid || out_ready;
   assign in_ready  = en;

   // Bubble contents never leave the block.
   assign sum  = out_valid ? g_stg[NBLK-1].s_q : '0;
   assign cout = out_valid & g_stg[NBLK-1].ctl_q.carry;
   assign ovf  = out_valid & (g_stg[NBLK-1].ctl_q.carry ^ g_stg[NBLK-1].g_last.cm_q);

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Directed and random-stream bench for three adder configurations: 16/4, 32/8 and 8/8.
module tb_pipelined_carry_select_adder;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ta, tbv;
   logic        tsub, tcin;
   logic [2:0]  iv, oready, ir, ov, co, of;
   logic [15:0] s16;
   logic [31:0] s32;
   logic [7:0]  s8;
   logic [31:0] sm [3];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   pipelined_carry_select_adder #(.WIDTH(16), .BLOCK(4)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(ta[15:0]), .b(tbv[15:0]),
      .sub(tsub), .cin(tcin), .out_valid(ov[0]), .out_ready(oready[0]), .sum(s16),
      .cout(co[0]), .ovf(of[0])
   );

   pipelined_carry_select_adder #(.WIDTH(32), .BLOCK(8)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(ta), .b(tbv),
      .sub(tsub), .cin(tcin), .out_valid(ov[1]), .out_ready(oready[1]), .sum(s32),
      .cout(co[1]), .ovf(of[1])
   );

   pipelined_carry_select_adder #(.WIDTH(8), .BLOCK(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(ta[7:0]), .b(tbv[7:0]),
      .sub(tsub), .cin(tcin), .out_valid(ov[2]), .out_ready(oready[2]), .sum(s8),
      .cout(co[2]), .ovf(of[2])
   );

   assign sm[0] = {16'd0, s16};
   assign sm[1] = s32;
   assign sm[2] = {24'd0, s8};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: {ovf, cout, sum} from a full-width sum and operand/result sign bits.
   function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                         input logic s, input logic ci);
      logic [31:0] m, am, bx, r;
      logic [32:0] full;
      logic        c, o;
      m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      am   = av & m;
      bx   = (bv ^ {32{s}}) & m;
      full = {1'b0, am} + {1'b0, bx} + {32'd0, (s | ci)};
      c    = full[w];
      r    = full[31:0] & m;
      o    = (am[w-1] == bx[w-1]) && (r[w-1] != am[w-1]);
      return {o, c, r};
   endfunction

   task automatic run_one(input int id, input int nblk, input logic [31:0] av,
                          input logic [31:0] bv, input logic s, input logic ci,
                          input logic [31:0] es, input logic ec, input logic eo, input string tag);
      ta = av; tbv = bv; tsub = s; tcin = ci;
      iv[id] = 1'b1;
      oready[id] = 1'b1;
      #1;
      chk({tag, "/in_ready"}, ir[id], 1'b1);
      tick();
      iv[id] = 1'b0;
      for (int i = 0; i < nblk - 1; i++) begin
         chk({tag, "/early_valid"}, ov[id], 1'b0);
         tick();
      end
      chk({tag, "/out_valid"}, ov[id], 1'b1);
      chk({tag, "/sum"}, sm[id], es);
      chk({tag, "/cout"}, co[id], ec);
      chk({tag, "/ovf"}, of[id], eo);
      tick();
      chk({tag, "/drained"}, ov[id], 1'b0);
   endtask

   task automatic stream(input int id, input int w, input int n);
      logic [33:0] q [$];
      logic [33:0] hv, exp, res;
      int          sent = 0;
      int          got = 0;
      bit          held = 1'b0;
      bit          orr;
      hv = '0;
      for (int cyc = 0; cyc < 30 * n && got < n; cyc++) begin
         orr        = ($urandom_range(0, 2) != 0);
         oready[id] = orr;
         iv[id]     = (sent < n);
         ta         = $urandom;
         tbv        = $urandom;
         tsub       = 1'($urandom_range(0, 1));
         tcin       = 1'($urandom_range(0, 1));
         #2;
         res = {of[id], co[id], sm[id]};
         if (held) begin
            chk("stall/valid", ov[id], 1'b1);
            chk("stall/hold", res, hv);
         end
         held = 1'b0;
         if (ov[id] && !orr) begin
            chk("stall/in_ready", ir[id], 1'b0);
            held = 1'b1;
            hv   = res;
         end
         if (ov[id] && orr) begin
            chk("stream/unexpected", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
               exp = q.pop_front();
               chk("stream/result", res, exp);
               got++;
            end
         end
         if (iv[id] && ir[id]) begin
            q.push_back(model(w, ta, tbv, tsub, tcin));
            sent++;
         end
         tick();
      end
      iv[id]     = 1'b0;
      oready[id] = 1'b1;
      chk("stream/count", got, n);
   endtask

   initial begin
      rst = 1'b1;
      iv = '0; oready = '1;
      ta = '0; tbv = '0; tsub = 1'b0; tcin = 1'b0;
      #2;
      chk("reset/out_valid", ov, 3'b000);
      chk("reset/sum16", sm[0], 32'h0);
      chk("reset/cout", co, 3'b000);
      chk("reset/ovf", of, 3'b000);
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("reset/in_ready", ir, 3'b111);
      chk("reset/idle", ov, 3'b000);
      tick();

      run_one(0, 4, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, "add_wrap");
      run_one(0, 4, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, "add_ovf");
      run_one(0, 4, 32'h1234, 32'h4321, 1'b0, 1'b1, 32'h5556, 1'b0, 1'b0, "add_cin");
      run_one(0, 4, 32'h0005, 32'h0007, 1'b1, 1'b0, 32'hFFFE, 1'b0, 1'b0, "sub_borrow");
      run_one(0, 4, 32'h8000, 32'h0001, 1'b1, 1'b0, 32'h7FFF, 1'b1, 1'b1, "sub_ovf");
      run_one(0, 4, 32'h0010, 32'h0010, 1'b1, 1'b1, 32'h0000, 1'b1, 1'b0, "sub_cin_ign");

      stream(0, 16, 20);

      // Three operations in flight, oldest already at the output, then reset.
      oready[0] = 1'b1;
      iv[0] = 1'b1;
      ta = 32'h1234; tbv = 32'h4321; tsub = 1'b0; tcin = 1'b0;
      tick();
      ta = 32'h0100; tbv = 32'h0001;
      tick();
      ta = 32'h0005; tbv = 32'h0007; tsub = 1'b1;
      tick();
      iv[0] = 1'b0;
      tick();
      chk("flush/pre_valid", ov[0], 1'b1);
      chk("flush/pre_sum", sm[0], 32'h5555);
      rst = 1'b1;
      #1;
      chk("flush/out_valid", ov[0], 1'b0);
      chk("flush/sum", sm[0], 32'h0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("flush/idle", ov[0], 1'b0);
      end
      run_one(0, 4, 32'h0001, 32'h0002, 1'b0, 1'b0, 32'h0003, 1'b0, 1'b0, "post_reset");

      run_one(1, 4, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "w32_wrap");
      run_one(1, 4, 32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, "w32_sub_ovf");
      stream(1, 32, 20);

      run_one(2, 1, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, "w8_ovf");
      run_one(2, 1, 32'h05, 32'h07, 1'b1, 1'b0, 32'hFE, 1'b0, 1'b0, "w8_sub");
      stream(2, 8, 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
